// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched instruction and PC, supports stall
// (hold) and flush (bubble), and exposes decode field slices of the held word.
module if_id_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic        valid_f,
    input  logic        stall_d,
    input  logic        flush_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc4_d,
    output logic        valid_d,
    output logic [5:0]  opcode_d,
    output logic [4:0]  rs_d,
    output logic [4:0]  rt_d,
    output logic [4:0]  rd_d,
    output logic [4:0]  shamt_d,
    output logic [5:0]  funct_d,
    output logic [15:0] imm16_d,
    output logic [25:0] j26_d
);

    logic [31:0] pcPlus4;
    logic        clearRegs;

    assign pcPlus4   = pc_f + 32'd4;
    // Flush inserts the same bubble as reset and outranks a concurrent stall.
    assign clearRegs = reset | flush_d;

    always_ff @(posedge clk) begin
        if (clearRegs) begin
            instr_d <= NOP_INSTR;
            pc_d    <= RESET_PC;
            pc4_d   <= RESET_PC + 32'd4;
            valid_d <= 1'b0;
        end else if (!stall_d) begin
            instr_d <= instr_f;
            pc_d    <= pc_f;
            pc4_d   <= pcPlus4;
            valid_d <= valid_f;
        end
    end

    assign opcode_d = instr_d[31:26];
    assign rs_d     = instr_d[25:21];
    assign rt_d     = instr_d[20:16];
    assign rd_d     = instr_d[15:11];
    assign shamt_d  = instr_d[10:6];
    assign funct_d  = instr_d[5:0];
    assign imm16_d  = instr_d[15:0];
    assign j26_d    = instr_d[25:0];

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: ordered vector table with hand-computed expectations,
// expected results queued at drive time and popped after the capturing edge.
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        reset, stall_d, flush_d, valid_f;
    logic [31:0] instr_f, pc_f;
    logic [31:0] instr_d, pc_d, pc4_d;
    logic        valid_d;
    logic [5:0]  opcode_d, funct_d;
    logic [4:0]  rs_d, rt_d, rd_d, shamt_d;
    logic [15:0] imm16_d;
    logic [25:0] j26_d;

    int vecCount = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    if_id_reg dut (
        .clk(clk), .reset(reset), .instr_f(instr_f), .pc_f(pc_f),
        .valid_f(valid_f), .stall_d(stall_d), .flush_d(flush_d),
        .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d), .valid_d(valid_d),
        .opcode_d(opcode_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .shamt_d(shamt_d), .funct_d(funct_d), .imm16_d(imm16_d), .j26_d(j26_d)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] expInstr;
        logic [31:0] expPc;
        logic [31:0] expPc4;
        logic        expVld;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        vld;
    } exp_t;

    exp_t sb[$];
    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int idx);
        if (act !== exp) begin
            missCount++;
            $display("FAIL vec%0d %s: got %h, want %h", idx, name, act, exp);
        end
    endtask

    task automatic applyVec(input vec_t v, input int idx);
        exp_t e;
        reset   = v.rst;
        stall_d = v.stall;
        flush_d = v.flush;
        valid_f = v.vld;
        instr_f = v.instr;
        pc_f    = v.pc;
        e.instr = v.expInstr;
        e.pc    = v.expPc;
        e.pc4   = v.expPc4;
        e.vld   = v.expVld;
        sb.push_back(e);
        @(posedge clk);
        #1;
        vecCount++;
        if (sb.size() == 0) begin
            missCount++;
            $display("FAIL vec%0d scoreboard: got empty queue, want one entry", idx);
        end else begin
            e = sb.pop_front();
            chk("instr_d", instr_d, e.instr, idx);
            chk("pc_d", pc_d, e.pc, idx);
            chk("pc4_d", pc4_d, e.pc4, idx);
            chk("valid_d", {31'd0, valid_d}, {31'd0, e.vld}, idx);
            chk("opcode_d", {26'd0, opcode_d}, {26'd0, e.instr[31:26]}, idx);
            chk("rs_d", {27'd0, rs_d}, {27'd0, e.instr[25:21]}, idx);
            chk("rt_d", {27'd0, rt_d}, {27'd0, e.instr[20:16]}, idx);
            chk("rd_d", {27'd0, rd_d}, {27'd0, e.instr[15:11]}, idx);
            chk("shamt_d", {27'd0, shamt_d}, {27'd0, e.instr[10:6]}, idx);
            chk("funct_d", {26'd0, funct_d}, {26'd0, e.instr[5:0]}, idx);
            chk("imm16_d", {16'd0, imm16_d}, {16'd0, e.instr[15:0]}, idx);
            chk("j26_d", {6'd0, j26_d}, {6'd0, e.instr[25:0]}, idx);
        end
    endtask

    initial begin
        //          rst   stl   fls   vld   instr_f        pc_f           instr_d        pc_d           pc4_d          valid_d
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0000_0000, 32'h0000_3000, 32'h0000_3004, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0000_1004, 32'h0000_0000, 32'h0000_3000, 32'h0000_3004, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3C01_1234, 32'h0000_3008, 32'h3C01_1234, 32'h0000_3008, 32'h0000_300C, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h2022_0005, 32'h0000_300C, 32'h2022_0005, 32'h0000_300C, 32'h0000_3010, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_3010, 32'h2022_0005, 32'h0000_300C, 32'h0000_3010, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h2222_2222, 32'h0000_3014, 32'h2022_0005, 32'h0000_300C, 32'h0000_3010, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h3333_3333, 32'h0000_3018, 32'h2022_0005, 32'h0000_300C, 32'h0000_3010, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h8C43_0004, 32'h0000_3010, 32'h8C43_0004, 32'h0000_3010, 32'h0000_3014, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_AAAA, 32'h0000_3014, 32'h0000_0000, 32'h0000_3000, 32'h0000_3004, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hBBBB_BBBB, 32'h0000_3018, 32'h0000_0000, 32'h0000_3000, 32'h0000_3004, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFC, 32'h0000_0020, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_4000, 32'h1234_5678, 32'h0000_4000, 32'h0000_4004, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hAC22_0008, 32'h0000_4004, 32'hAC22_0008, 32'h0000_4004, 32'h0000_4008, 1'b1};
        vt[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hCCCC_CCCC, 32'h0000_4008, 32'h0000_0000, 32'h0000_3000, 32'h0000_3004, 1'b0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0800_0C01, 32'h0000_3000, 32'h0800_0C01, 32'h0000_3000, 32'h0000_3004, 1'b1};

        reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; valid_f = 1'b0;
        instr_f = '0; pc_f = '0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            applyVec(vt[i], i);
            // Spot-check decode of the lui word independently of the table slices.
            if (i == 2) begin
                vecCount++;
                if (opcode_d !== 6'h0F || rt_d !== 5'd1 || imm16_d !== 16'h1234 || rs_d !== 5'd0) begin
                    missCount++;
                    $display("FAIL lui_fields: got op=%h rs=%h rt=%h imm=%h, want op=0f rs=00 rt=01 imm=1234",
                             opcode_d, rs_d, rt_d, imm16_d);
                end
            end
        end

        // Multi-cycle flush: pc_d must sit at the reset PC on every flushed edge.
        for (int k = 0; k < 3; k++) begin
            reset = 1'b0; stall_d = (k == 1); flush_d = 1'b1; valid_f = 1'b1;
            instr_f = 32'h0100_0000 + k; pc_f = 32'h0000_5000 + 32'(k * 4);
            @(posedge clk); #1;
            vecCount++;
            if (pc_d !== 32'h0000_3000 || instr_d !== 32'h0 || valid_d !== 1'b0) begin
                missCount++;
                $display("FAIL flush_hold%0d: got pc=%h instr=%h v=%b, want pc=00003000 instr=00000000 v=0",
                         k, pc_d, instr_d, valid_d);
            end
        end

        // Unknown instruction on an invalid fetch cycle must leave valid_d clean.
        reset = 1'b0; stall_d = 1'b0; flush_d = 1'b0; valid_f = 1'b0;
        instr_f = 'x; pc_f = 32'h0000_6000;
        @(posedge clk); #1;
        vecCount++;
        if (valid_d !== 1'b0 || pc_d !== 32'h0000_6000 || pc4_d !== 32'h0000_6004) begin
            missCount++;
            $display("FAIL x_invalid: got v=%b pc=%h pc4=%h, want v=0 pc=00006000 pc4=00006004",
                     valid_d, pc_d, pc4_d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
